// File: rtl/soma_display_pkg.sv
// ============================================================================
// Module      : soma_display_pkg
// Description : Shared types, constants and helpers for the soma_display
//               block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soma_display_pkg;

  localparam int N_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Active-high segment patterns, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-BCD codes reuse the spare nibble values to select the glyphs.
  localparam logic [3:0] CODE_R     = 4'hA;
  localparam logic [3:0] CODE_E     = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      CODE_R:  seg_of = SEG_R;
      CODE_E:  seg_of = SEG_E;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/soma_display_decod7seg.sv
// ============================================================================
// Module      : decod7seg
// Description : Combinational digit-code to 7-segment decoder with selectable
//               output polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decod7seg
  import soma_display_pkg::*;
#(
  parameter logic SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] seg_ah;

  always_comb begin
    seg_ah = seg_of(bcd);
    seg    = SEG_ATIVO_BAIXO ? ~seg_ah : seg_ah;
  end

endmodule

`default_nettype wire

// File: rtl/soma_display.sv
// ============================================================================
// Module      : soma_display
// Description : Converts an 8-bit sum to three 7-segment digits using a
//               sequential double-dabble, with leading-zero blanking.
//               Optional macro SOMA_DISPLAY_ERRO_EN shows "Err" on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soma_display
  import soma_display_pkg::*;
#(
  parameter logic SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] soma,
  input  logic              pronto,
  input  logic              erro,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic              ocupado,
  output logic              valido
);

  localparam logic [6:0] C_SEG_OFF = SEG_ATIVO_BAIXO ? ~SEG_BLANK : SEG_BLANK;

  state_t            state_q, state_d;
  logic              pronto_q, pronto_d;
  logic [N_BITS-1:0] bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              valido_q, valido_d;
  logic [6:0]        hex0_q, hex0_d;
  logic [6:0]        hex1_q, hex1_d;
  logic [6:0]        hex2_q, hex2_d;

  logic              start_ev;
  logic [11:0]       bcd_adj;
  logic [3:0]        code0, code1, code2;
  logic [6:0]        seg0, seg1, seg2;

`ifdef SOMA_DISPLAY_ERRO_EN
  logic              erro_q, erro_d;
`else
  logic              unused_erro;
  assign unused_erro = erro;
`endif

  assign start_ev = pronto & ~pronto_q;
  assign bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  // Leading zeros blanked; units digit is always shown.
  always_comb begin
    code2 = (bcd_q[11:8] == 4'd0) ? CODE_BLANK : bcd_q[11:8];
    code1 = (bcd_q[11:4] == 8'd0) ? CODE_BLANK : bcd_q[7:4];
    code0 = bcd_q[3:0];
`ifdef SOMA_DISPLAY_ERRO_EN
    if (erro_q) begin
      code2 = CODE_E;
      code1 = CODE_R;
      code0 = CODE_R;
    end
`endif
  end

  decod7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_dig0 (.bcd(code0), .seg(seg0));
  decod7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_dig1 (.bcd(code1), .seg(seg1));
  decod7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_dig2 (.bcd(code2), .seg(seg2));

  always_comb begin
    state_d  = state_q;
    pronto_d = pronto;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    valido_d = 1'b0;
    hex0_d   = hex0_q;
    hex1_d   = hex1_q;
    hex2_d   = hex2_q;
`ifdef SOMA_DISPLAY_ERRO_EN
    erro_d   = erro_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          bin_d   = soma;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
`ifdef SOMA_DISPLAY_ERRO_EN
          erro_d  = erro;
`endif
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hex0_d   = seg0;
        hex1_d   = seg1;
        hex2_d   = seg2;
        valido_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pronto_q <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= 12'd0;
      cnt_q    <= 3'd0;
      valido_q <= 1'b0;
      hex0_q   <= C_SEG_OFF;
      hex1_q   <= C_SEG_OFF;
      hex2_q   <= C_SEG_OFF;
`ifdef SOMA_DISPLAY_ERRO_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pronto_q <= pronto_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      valido_q <= valido_d;
      hex0_q   <= hex0_d;
      hex1_q   <= hex1_d;
      hex2_q   <= hex2_d;
`ifdef SOMA_DISPLAY_ERRO_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign hex0    = hex0_q;
  assign hex1    = hex1_q;
  assign hex2    = hex2_q;
  assign valido  = valido_q;
  assign ocupado = (state_q == ST_CONV) || (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_soma_display.sv
// ============================================================================
// Module      : tb_soma_display
// Description : Directed self-checking bench for soma_display (default
//               active-low segments); honours SOMA_DISPLAY_ERRO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soma_display;

  // Active-low glyphs, bit0=a ... bit6=g
  localparam logic [6:0] L_0  = 7'h40;
  localparam logic [6:0] L_1  = 7'h79;
  localparam logic [6:0] L_2  = 7'h24;
  localparam logic [6:0] L_3  = 7'h30;
  localparam logic [6:0] L_5  = 7'h12;
  localparam logic [6:0] L_7  = 7'h78;
  localparam logic [6:0] L_E  = 7'h06;
  localparam logic [6:0] L_R  = 7'h2F;
  localparam logic [6:0] L_BL = 7'h7F;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] soma;
  logic       pronto;
  logic       erro;
  logic [6:0] hex0, hex1, hex2;
  logic       ocupado, valido;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  soma_display #(.SEG_ATIVO_BAIXO(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .soma    (soma),
    .pronto  (pronto),
    .erro    (erro),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .ocupado (ocupado),
    .valido  (valido)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valido === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                            input logic [6:0] e0);
    check({tag, ".hex2"}, 32'(hex2), 32'(e2));
    check({tag, ".hex1"}, 32'(hex1), 32'(e1));
    check({tag, ".hex0"}, 32'(hex0), 32'(e0));
  endtask

  // Full conversion: start at E0, checks through E10.
  task automatic run(input string tag, input logic [7:0] v, input logic e,
                     input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    int p0;
    soma   = v;
    erro   = e;
    pronto = 1'b1;
    tick();
    p0 = pulses;
    check({tag, ".busy_e0"}, 32'(ocupado), 32'd1);
    soma = ~v;
    erro = ~e;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (valido !== 1'b0 || ocupado !== 1'b1)
        check({tag, ".conv_flags"}, 32'({ocupado, valido}), 32'b10);
    end
    tick();
    check({tag, ".valido_e9"}, 32'(valido), 32'd1);
    check({tag, ".idle_e9"}, 32'(ocupado), 32'd0);
    check_disp(tag, e2, e1, e0);
    tick();
    check({tag, ".valido_e10"}, 32'(valido), 32'd0);
    pronto = 1'b0;
    tick();
    check({tag, ".pulses"}, 32'(pulses - p0), 32'd1);
  endtask

  initial begin
    int p0;
    reset  = 1'b1;
    pronto = 1'b0;
    erro   = 1'b0;
    soma   = 8'd0;
    repeat (3) tick();
    check("rst.ocupado", 32'(ocupado), 32'd0);
    check("rst.valido", 32'(valido), 32'd0);
    check_disp("rst", L_BL, L_BL, L_BL);
    reset = 1'b0;
    tick();

    run("s0",   8'd0,   1'b0, L_BL, L_BL, L_0);
    run("s255", 8'd255, 1'b0, L_2,  L_5,  L_5);
    run("s105", 8'd105, 1'b0, L_1,  L_0,  L_5);
    run("s7",   8'd7,   1'b0, L_BL, L_BL, L_7);
    run("s10",  8'd10,  1'b0, L_BL, L_1,  L_0);
`ifdef SOMA_DISPLAY_ERRO_EN
    run("err200", 8'd200, 1'b1, L_E, L_R, L_R);
`else
    run("err200", 8'd200, 1'b1, L_2, L_0, L_0);
`endif

    // Hold between conversions
    soma = 8'd33;
    repeat (4) tick();
`ifdef SOMA_DISPLAY_ERRO_EN
    check_disp("hold", L_E, L_R, L_R);
`else
    check_disp("hold", L_2, L_0, L_0);
`endif

    // Start during busy is ignored; soma change after capture has no effect
    erro   = 1'b0;
    soma   = 8'd42;
    pronto = 1'b1;
    tick();
    p0     = pulses;
    pronto = 1'b0;
    tick();
    tick();
    tick();
    soma   = 8'd99;
    pronto = 1'b1;
    tick();
    repeat (4) tick();
    check("busy.pre_e9", 32'(valido), 32'd0);
    tick();
    check("busy.valido_e9", 32'(valido), 32'd1);
    check_disp("busy", L_BL, 7'h19, 7'h24);
    repeat (12) tick();
    check("busy.pulses", 32'(pulses - p0), 32'd1);
    check("busy.no_restart", 32'(ocupado), 32'd0);
    pronto = 1'b0;
    tick();

    // Reset at E4 aborts; pronto held through release restarts
    soma   = 8'd123;
    pronto = 1'b1;
    tick();
    p0 = pulses;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("abort.ocupado", 32'(ocupado), 32'd0);
    check("abort.valido", 32'(valido), 32'd0);
    check_disp("abort", L_BL, L_BL, L_BL);
    reset = 1'b0;
    tick();
    check("restart.ocupado", 32'(ocupado), 32'd1);
    repeat (8) tick();
    check("restart.pre_e9", 32'(valido), 32'd0);
    tick();
    check("restart.valido", 32'(valido), 32'd1);
    check_disp("restart", L_1, L_2, L_3);
    pronto = 1'b0;
    repeat (3) tick();
    check("abort.pulses", 32'(pulses - p0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
